// File: rtl/xaui_rx_lane_autosteer.sv
// Registered XAUI RX lane steering with per-channel /S/-based lane-reversal detection.
// Each channel steers manually from cfg_steer or locks onto the lane order after LOCK_COUNT consistent /S/ votes.
module xaui_rx_lane_autosteer #(
  parameter int unsigned     N_CH       = 8,
  parameter int unsigned     LANES      = 4,
  parameter int unsigned     BPL        = 2,
  parameter int unsigned     LOCK_COUNT = 16,
  parameter logic [N_CH-1:0] STEER_INIT = '0,
  parameter logic [N_CH-1:0] AUTO_INIT  = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CH-1:0]               cfg_auto,
  input  logic [N_CH-1:0]               cfg_steer,
  input  logic [N_CH*LANES*BPL*8-1:0]   rxdata_in,
  input  logic [N_CH*LANES*BPL-1:0]     rxcharisk_in,
  input  logic [N_CH*LANES*BPL-1:0]     rxcodevalid_in,
  input  logic [N_CH*LANES-1:0]         rxsyncok_in,
  input  logic [N_CH*LANES-1:0]         rxlock_in,
  output logic [N_CH*LANES*BPL*8-1:0]   rxdata_out,
  output logic [N_CH*LANES*BPL-1:0]     rxcharisk_out,
  output logic [N_CH*LANES*BPL-1:0]     rxcodevalid_out,
  output logic [N_CH*LANES-1:0]         rxsyncok_out,
  output logic [N_CH*LANES-1:0]         rxlock_out,
  output logic [N_CH-1:0]               steer_active,
  output logic [N_CH-1:0]               auto_locked
);

  localparam int unsigned DW       = BPL * 8;
  localparam logic [7:0]  LOCK_CNT = 8'(LOCK_COUNT);

  typedef enum logic {HUNT, LOCKED} state_t;

  logic [N_CH*LANES*BPL*8-1:0] rxdata_d, rxdata_q;
  logic [N_CH*LANES*BPL-1:0]   rxcharisk_d, rxcharisk_q;
  logic [N_CH*LANES*BPL-1:0]   rxcodevalid_d, rxcodevalid_q;
  logic [N_CH*LANES-1:0]       rxsyncok_d, rxsyncok_q;
  logic [N_CH*LANES-1:0]       rxlock_d, rxlock_q;

  logic [N_CH-1:0] steer_d, steer_q;
  logic [N_CH-1:0] cand_d, cand_q;
  logic [N_CH-1:0] auto_q;
  state_t          state_d [N_CH];
  state_t          state_q [N_CH];
  logic [7:0]      cnt_d [N_CH];
  logic [7:0]      cnt_q [N_CH];

  // Whole-lane selection from the registered steer bit, so a steer change never splits a word.
  always_comb begin : steer_path
    int unsigned src, dst;
    rxdata_d      = '0;
    rxcharisk_d   = '0;
    rxcodevalid_d = '0;
    rxsyncok_d    = '0;
    rxlock_d      = '0;
    for (int unsigned j = 0; j < N_CH; j++) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        dst = j * LANES + l;
        src = steer_q[j] ? (j * LANES + LANES - 1 - l) : dst;
        rxdata_d[dst*DW +: DW]        = rxdata_in[src*DW +: DW];
        rxcharisk_d[dst*BPL +: BPL]   = rxcharisk_in[src*BPL +: BPL];
        rxcodevalid_d[dst*BPL +: BPL] = rxcodevalid_in[src*BPL +: BPL];
        rxsyncok_d[dst]               = rxsyncok_in[src];
        rxlock_d[dst]                 = rxlock_in[src];
      end
    end
  end

  always_comb begin : steer_fsm
    int unsigned i0, i1;
    logic       sync_all, hit_n, hit_r, v_valid, v_rev, b_cand;
    logic [7:0] b_cnt;
    steer_d = steer_q;
    cand_d  = cand_q;
    for (int unsigned j = 0; j < N_CH; j++) begin
      state_d[j] = state_q[j];
      cnt_d[j]   = cnt_q[j];
      sync_all   = &rxsyncok_in[j*LANES +: LANES];
      hit_n      = 1'b0;
      hit_r      = 1'b0;
      for (int unsigned b = 0; b < BPL; b++) begin
        i0 = (j * LANES) * BPL + b;
        i1 = (j * LANES + LANES - 1) * BPL + b;
        hit_n = hit_n | ((rxdata_in[i0*8 +: 8] == 8'hFB) & rxcharisk_in[i0] & rxcodevalid_in[i0]);
        hit_r = hit_r | ((rxdata_in[i1*8 +: 8] == 8'hFB) & rxcharisk_in[i1] & rxcodevalid_in[i1]);
      end
      v_valid = sync_all & (hit_n ^ hit_r);
      v_rev   = hit_r;
      // First auto cycle hunts from the steer value already applied.
      b_cand  = auto_q[j] ? cand_q[j] : steer_q[j];
      b_cnt   = auto_q[j] ? cnt_q[j] : 8'd0;

      if (!cfg_auto[j]) begin
        state_d[j] = HUNT;
        cnt_d[j]   = 8'd0;
        steer_d[j] = cfg_steer[j];
      end else begin
        unique case (state_q[j])
          HUNT: begin
            cand_d[j] = b_cand;
            cnt_d[j]  = b_cnt;
            if (v_valid) begin
              if (v_rev == b_cand) begin
                cnt_d[j] = (b_cnt == 8'hFF) ? b_cnt : b_cnt + 8'd1;
              end else begin
                cand_d[j] = v_rev;
                cnt_d[j]  = 8'd1;
              end
            end
            if (cnt_d[j] == LOCK_CNT) begin
              state_d[j] = LOCKED;
              steer_d[j] = cand_d[j];
              cnt_d[j]   = 8'd0;
            end
          end
          LOCKED: begin
            // In LOCKED the counter tracks the run of votes opposing the held steer.
            if (!sync_all) begin
              state_d[j] = HUNT;
              cnt_d[j]   = 8'd0;
            end else if (v_valid) begin
              if (v_rev != steer_q[j]) begin
                cnt_d[j] = cnt_q[j] + 8'd1;
                if (cnt_d[j] == LOCK_CNT) begin
                  state_d[j] = HUNT;
                  cnt_d[j]   = 8'd0;
                end
              end else begin
                cnt_d[j] = 8'd0;
              end
            end
          end
          default: begin
            state_d[j] = HUNT;
            cnt_d[j]   = 8'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxdata_q      <= '0;
      rxcharisk_q   <= '0;
      rxcodevalid_q <= '0;
      rxsyncok_q    <= '0;
      rxlock_q      <= '0;
      steer_q       <= STEER_INIT;
      cand_q        <= STEER_INIT;
      auto_q        <= AUTO_INIT;
      for (int unsigned j = 0; j < N_CH; j++) begin
        state_q[j] <= HUNT;
        cnt_q[j]   <= 8'd0;
      end
    end else begin
      rxdata_q      <= rxdata_d;
      rxcharisk_q   <= rxcharisk_d;
      rxcodevalid_q <= rxcodevalid_d;
      rxsyncok_q    <= rxsyncok_d;
      rxlock_q      <= rxlock_d;
      steer_q       <= steer_d;
      cand_q        <= cand_d;
      auto_q        <= cfg_auto;
      for (int unsigned j = 0; j < N_CH; j++) begin
        state_q[j] <= state_d[j];
        cnt_q[j]   <= cnt_d[j];
      end
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < N_CH; j++) begin
      auto_locked[j] = (state_q[j] == LOCKED);
    end
  end

  assign rxdata_out      = rxdata_q;
  assign rxcharisk_out   = rxcharisk_q;
  assign rxcodevalid_out = rxcodevalid_q;
  assign rxsyncok_out    = rxsyncok_q;
  assign rxlock_out      = rxlock_q;
  assign steer_active    = steer_q;

endmodule

// File: tb/tb_xaui_rx_lane_autosteer.sv
// Directed bench for xaui_rx_lane_autosteer: manual steering, /S/ lock, unlock paths and reset.
module tb_xaui_rx_lane_autosteer;

  localparam int unsigned N_CH  = 8;
  localparam int unsigned LANES = 4;
  localparam int unsigned BPL   = 2;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [N_CH-1:0]             cfg_auto, cfg_steer;
  logic [N_CH*LANES*BPL*8-1:0] rxdata_in, rxdata_out;
  logic [N_CH*LANES*BPL-1:0]   rxcharisk_in, rxcharisk_out;
  logic [N_CH*LANES*BPL-1:0]   rxcodevalid_in, rxcodevalid_out;
  logic [N_CH*LANES-1:0]       rxsyncok_in, rxsyncok_out;
  logic [N_CH*LANES-1:0]       rxlock_in, rxlock_out;
  logic [N_CH-1:0]             steer_active, auto_locked;

  int n_checks = 0;
  int n_fail   = 0;

  xaui_rx_lane_autosteer #(
    .N_CH       (N_CH),
    .LANES      (LANES),
    .BPL        (BPL),
    .LOCK_COUNT (16),
    .STEER_INIT (8'h05),
    .AUTO_INIT  (8'h00)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_auto        (cfg_auto),
    .cfg_steer       (cfg_steer),
    .rxdata_in       (rxdata_in),
    .rxcharisk_in    (rxcharisk_in),
    .rxcodevalid_in  (rxcodevalid_in),
    .rxsyncok_in     (rxsyncok_in),
    .rxlock_in       (rxlock_in),
    .rxdata_out      (rxdata_out),
    .rxcharisk_out   (rxcharisk_out),
    .rxcodevalid_out (rxcodevalid_out),
    .rxsyncok_out    (rxsyncok_out),
    .rxlock_out      (rxlock_out),
    .steer_active    (steer_active),
    .auto_locked     (auto_locked)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] out_lane(input int ch, input int l);
    return rxdata_out[(ch*LANES + l)*16 +: 16];
  endfunction

  task automatic set_lane(input int ch, input int l, input logic [15:0] d);
    rxdata_in[(ch*LANES + l)*16 +: 16] = d;
  endtask

  // /S/ placed in the upper byte of the lane.
  task automatic set_s(input int ch, input int l, input logic on);
    int idx;
    idx = ch*LANES + l;
    rxdata_in[idx*16 + 8 +: 8] = on ? 8'hFB : 8'h00;
    rxcharisk_in[idx*2 + 1]    = on;
  endtask

  task automatic votes(input int ch, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      set_s(ch, l, 1'b1);
      tick;
      set_s(ch, l, 1'b0);
    end
  endtask

  task automatic randomize_data;
    for (int i = 0; i < 16; i++) rxdata_in[i*32 +: 32] = $urandom | 32'h1;
    rxcharisk_in = {$urandom, $urandom};
  endtask

  initial begin
    rst            = 1'b1;
    cfg_auto       = 8'h00;
    cfg_steer      = 8'h05;
    rxcodevalid_in = '1;
    rxsyncok_in    = '1;
    rxlock_in      = '1;
    randomize_data();
    tick;
    tick;
    check("rst_steer",   32'(steer_active), 32'h05);
    check("rst_locked",  32'(auto_locked), 32'h00);
    check("rst_data",    32'(|rxdata_out), 32'h0);
    check("rst_charisk", 32'(|rxcharisk_out), 32'h0);
    check("rst_syncok",  32'(|rxsyncok_out), 32'h0);

    rxdata_in    = '0;
    rxcharisk_in = '0;
    rxsyncok_in  = '0;
    rxlock_in    = '0;
    rxcodevalid_in = '0;
    rst = 1'b0;
    tick;
    check("post_rst_data",  32'(|rxdata_out), 32'h0);
    check("post_rst_flags", 32'(|{rxcharisk_out, rxcodevalid_out, rxsyncok_out, rxlock_out}), 32'h0);

    // Manual steering: ch0 reversed, ch1 pass-through.
    rxcodevalid_in = '1;
    rxsyncok_in    = '1;
    rxlock_in      = '1;
    set_lane(0, 0, 16'h1111);
    set_lane(0, 1, 16'h2222);
    set_lane(0, 2, 16'h3333);
    set_lane(0, 3, 16'h4444);
    set_lane(1, 0, 16'hAAAA);
    rxcharisk_in[7:0] = 8'h01;
    rxsyncok_in[3:0]  = 4'b0001;
    rxlock_in[3:0]    = 4'b0011;
    tick;
    check("man_l0", 32'(out_lane(0, 0)), 32'h4444);
    check("man_l1", 32'(out_lane(0, 1)), 32'h3333);
    check("man_l2", 32'(out_lane(0, 2)), 32'h2222);
    check("man_l3", 32'(out_lane(0, 3)), 32'h1111);
    check("man_charisk", 32'(rxcharisk_out[7:0]), 32'h40);
    check("man_codevalid", 32'(rxcodevalid_out[7:0]), 32'hFF);
    check("man_syncok", 32'(rxsyncok_out[3:0]), 32'h8);
    check("man_lock", 32'(rxlock_out[3:0]), 32'hC);
    check("man_ch1_pass", 32'(out_lane(1, 0)), 32'hAAAA);

    cfg_steer = 8'h04;
    tick;
    check("man_steer_chg", 32'(steer_active), 32'h04);
    check("man_old_steer_word", 32'(out_lane(0, 0)), 32'h4444);
    tick;
    check("man_new_steer_word", 32'(out_lane(0, 0)), 32'h1111);

    rxdata_in    = '0;
    rxcharisk_in = '0;
    rxsyncok_in  = '1;
    rxlock_in    = '1;

    // Auto lock on ch2 from reversed votes, with idle and NONE cycles in between.
    cfg_steer = 8'h00;
    tick;
    check("auto_pre_steer", 32'(steer_active), 32'h00);
    cfg_auto = 8'h04;
    tick;
    for (int i = 0; i < 8; i++) begin
      votes(2, 3, 1);
      tick;
    end
    set_s(2, 0, 1'b1);
    set_s(2, 3, 1'b1);
    tick;
    set_s(2, 0, 1'b0);
    set_s(2, 3, 1'b0);
    set_s(2, 0, 1'b1);
    rxsyncok_in[2*LANES + 2] = 1'b0;
    tick;
    set_s(2, 0, 1'b0);
    rxsyncok_in = '1;
    for (int i = 0; i < 7; i++) begin
      votes(2, 3, 1);
      tick;
    end
    check("auto_15_locked", 32'(auto_locked), 32'h00);
    check("auto_15_steer",  32'(steer_active), 32'h00);
    votes(2, 3, 1);
    check("auto_16_locked", 32'(auto_locked), 32'h04);
    check("auto_16_steer",  32'(steer_active), 32'h04);
    set_lane(2, 0, 16'hBEEF);
    tick;
    check("auto_rev_l3", 32'(out_lane(2, 3)), 32'hBEEF);
    check("auto_rev_l0", 32'(out_lane(2, 0)), 32'h0000);
    set_lane(2, 0, 16'h0000);

    // Sync drop unlocks; relock needs 16 fresh votes.
    rxsyncok_in[2*LANES + 1] = 1'b0;
    tick;
    rxsyncok_in = '1;
    check("sync_drop_locked", 32'(auto_locked), 32'h00);
    check("sync_drop_steer",  32'(steer_active), 32'h04);
    votes(2, 3, 15);
    check("relock_15", 32'(auto_locked), 32'h00);
    votes(2, 3, 1);
    check("relock_16", 32'(auto_locked), 32'h04);

    // Opposite votes while locked; an idle cycle does not break the run.
    votes(2, 0, 8);
    tick;
    votes(2, 0, 7);
    check("opp_15_locked", 32'(auto_locked), 32'h04);
    votes(2, 0, 1);
    check("opp_16_locked", 32'(auto_locked), 32'h00);
    check("opp_16_steer",  32'(steer_active), 32'h04);

    // ch3: hunt starts from applied steer=1, candidate flips on first NORMAL.
    cfg_steer = 8'h08;
    tick;
    check("ch3_man_steer", 32'(steer_active), 32'h0C);
    cfg_auto = 8'h0C;
    tick;
    votes(3, 3, 10);
    votes(3, 0, 1);
    votes(3, 0, 14);
    check("ch3_pre_locked", 32'(auto_locked), 32'h00);
    check("ch3_pre_steer",  32'(steer_active), 32'h0C);
    votes(3, 0, 1);
    check("ch3_locked", 32'(auto_locked), 32'h08);
    check("ch3_steer",  32'(steer_active), 32'h04);

    // Leaving auto mode drops lock and follows cfg_steer.
    cfg_auto = 8'h04;
    tick;
    check("auto_off_locked", 32'(auto_locked), 32'h00);
    check("auto_off_steer",  32'(steer_active), 32'h0C);

    // Re-enter auto, lock, then reset mid-lock.
    cfg_auto = 8'h0C;
    tick;
    votes(3, 3, 16);
    check("ch3_relock", 32'(auto_locked), 32'h08);
    randomize_data();
    rst = 1'b1;
    tick;
    check("mid_rst_locked", 32'(auto_locked), 32'h00);
    check("mid_rst_steer",  32'(steer_active), 32'h05);
    check("mid_rst_data",   32'(|rxdata_out), 32'h0);
    rst = 1'b0;
    rxdata_in    = '0;
    rxcharisk_in = '0;
    tick;
    check("post_mid_rst_locked", 32'(auto_locked), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xaui_rx_lane_autosteer.md
Name: xaui_rx_lane_autosteer

Overview:
Parametrised, registered successor to the static XAUI RX lane-steer stage, placed between the GT receive outputs and the XAUI core RX inputs. Each channel can reverse its lane order per a static or runtime setting. In auto mode, each channel detects lane reversal from the position of /S/ (K27.7, 0xFB) and locks the steering after repeated consistent evidence. Per-channel lock status goes to software registers.

Parameters:
N_CH, 8, number of XAUI channels
LANES, 4, lanes per channel
BPL, 2, bytes per lane per clock
LOCK_COUNT, 16, consecutive consistent /S/ votes required to lock (2..255)
STEER_INIT, {N_CH{1'b0}}, per-channel steer value after reset (1 = reversed)
AUTO_INIT, {N_CH{1'b0}}, per-channel auto-detect enable after reset

Ports:
clk  in  1  RX user clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cfg_auto  in  N_CH  per-channel auto-detect enable; 0 = steer from cfg_steer
cfg_steer  in  N_CH  per-channel manual steer, used when cfg_auto[j]=0
rxdata_in  in  N_CH*LANES*BPL*8  raw GT data; lane L of ch j at [(j*LANES+L)*BPL*8 +: BPL*8]
rxcharisk_in  in  N_CH*LANES*BPL  per-byte K flag, same lane indexing
rxcodevalid_in  in  N_CH*LANES*BPL  per-byte code-valid
rxsyncok_in  in  N_CH*LANES  per-lane sync OK
rxlock_in  in  N_CH*LANES  per-lane CDR lock
rxdata_out  out  as rxdata_in  steered, registered
rxcharisk_out  out  as rxcharisk_in  steered, registered
rxcodevalid_out  out  as rxcodevalid_in  steered, registered
rxsyncok_out  out  N_CH*LANES  steered, registered
rxlock_out  out  N_CH*LANES  steered, registered
steer_active  out  N_CH  steer value currently applied per channel
auto_locked  out  N_CH  1 = channel in LOCKED state

Behaviour:
- Steering: reversed channel maps out lane L <- in lane LANES-1-L for every field; byte order inside a lane is preserved. Non-reversed = pass-through.
- Latency: exactly 1 clk from inputs to all *_out. steer_active changes take effect on the data path the cycle after the change, with no partial-lane mixing within a word.
- Reset: all *_out data/flags = 0; steer_active = STEER_INIT; auto_locked = 0; every channel FSM = HUNT; vote counters = 0; cfg inputs are sampled from the first cycle after reset.
- Manual (cfg_auto[j]=0): steer_active[j] = cfg_steer[j] registered (1 clk). FSM is held in HUNT and counter = 0.
- Vote per channel per cycle, from raw inputs:
  - NORMAL if any byte of raw lane 0 = 0xFB with charisk=1 and codevalid=1.
  - REVERSED if the same holds on raw lane LANES-1.
  - NONE if neither or both.
  - No vote is generated unless all LANES rxsyncok_in bits of the channel are 1.
- FSM per channel (cfg_auto[j]=1):
  - HUNT: NONE leaves the counter unchanged. A vote equal to the candidate increments the counter (saturating). A differing vote sets candidate := vote and counter := 1. When counter reaches LOCK_COUNT, go to LOCKED, steer_active := candidate, auto_locked := 1, in the same cycle as the counter reaches LOCK_COUNT.
  - LOCKED: steer is held, and votes are ignored except as below. Any rxsyncok_in lane = 0 for that channel, or LOCK_COUNT consecutive opposite votes (NONE does not break the run), returns the FSM to HUNT: counter := 0, auto_locked := 0. steer_active keeps its last value until the next lock.
- cfg_auto 1->0 mid-operation: FSM goes to HUNT and auto_locked drops next cycle. steer_active follows cfg_steer. cfg_auto 0->1: hunt starts with candidate = current steer_active, counter 0.
- rst asserted mid-lock: all state returns to reset values on the next edge.
- Channels are fully independent; no cross-channel state.

Test Plan:
- Reset with STEER_INIT=8'h05 -> steer_active=8'h05, auto_locked=0, all outputs 0 during reset and 1 cycle after.
- Manual cfg_steer[0]=1, lanes carry 0x1111/0x2222/0x3333/0x4444 on lanes 0..3 -> one cycle later ch0 out lanes 0..3 = 0x4444/0x3333/0x2222/0x1111, charisk/syncok bits reversed likewise.
- Auto ch2, LOCK_COUNT=16, 16 /S/ on raw lane 3 interleaved with idle cycles -> auto_locked[2]=1 on the 16th vote, steer_active[2]=1, and data reversed from the next cycle.
- HUNT with 10 REVERSED votes then 1 NORMAL vote then 15 NORMAL votes -> lock only on the 16th NORMAL vote, steer_active=0.
- Locked ch2, drop rxsyncok_in lane 1 for 1 cycle -> auto_locked[2]=0 next cycle, steer_active[2] stays 1, and the ch2 FSM relocks after 16 fresh votes.
- /S/ on lanes 0 and 3 simultaneously, or while any syncok=0 -> counter unchanged (NONE vote).
